// File: rtl/sha1_round_ctrl.sv
// SHA-1 block controller and message scheduler: accepts 16-word blocks, sequences the 80-round datapath, folds chaining values.
// Optional SHA1_CTRL_DIGEST_HOLD_EN: digest_valid is held in DONE until digest_ack.
module sha1_round_ctrl (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_word,
    input  logic         in_init,
    input  logic         in_last,
`ifdef SHA1_CTRL_DIGEST_HOLD_EN
    input  logic         digest_ack,
`endif
    output logic         feed,
    output logic         next,
    output logic [31:0]  w,
    output logic [6:0]   round,
    output logic [31:0]  ia,
    output logic [31:0]  ib,
    output logic [31:0]  ic,
    output logic [31:0]  id,
    output logic [31:0]  ie,
    input  logic [31:0]  a,
    input  logic [31:0]  b,
    input  logic [31:0]  c,
    input  logic [31:0]  d,
    input  logic [31:0]  e,
    output logic [159:0] digest,
    output logic         digest_valid,
    output logic         busy
);

    localparam logic [31:0] IV0 = 32'h67452301;
    localparam logic [31:0] IV1 = 32'hefcdab89;
    localparam logic [31:0] IV2 = 32'h98badcfe;
    localparam logic [31:0] IV3 = 32'h10325476;
    localparam logic [31:0] IV4 = 32'hc3d2e1f0;

    typedef enum logic [2:0] {LOAD, FEED, ROUND, FINAL, DONE} ctrlState;

    ctrlState    state;
    ctrlState    stateNext;
    logic [3:0]  count;
    logic [6:0]  t;
    logic        lastBlk;
    logic [31:0] wBuf [16];
    logic [31:0] h0, h1, h2, h3, h4;

    logic [3:0]  idx0, idx3, idx8, idx14;
    logic [31:0] wMix;
    logic [31:0] wSched;

    // Sixteen-entry circular schedule: offsets -3/-8/-14 taken mod 16 by 4-bit wrap.
    always_comb begin
        idx0   = t[3:0];
        idx3   = t[3:0] - 4'd3;
        idx8   = t[3:0] + 4'd8;
        idx14  = t[3:0] + 4'd2;
        wMix   = wBuf[idx3] ^ wBuf[idx8] ^ wBuf[idx14] ^ wBuf[idx0];
        wSched = (t < 7'd16) ? wBuf[idx0] : {wMix[30:0], wMix[31]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOAD;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext    = state;
        in_ready     = 1'b0;
        feed         = 1'b0;
        next         = 1'b0;
        w            = '0;
        round        = '0;
        digest_valid = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && count == 4'd15) stateNext = FEED;
            end
            FEED: begin
                feed      = 1'b1;
                stateNext = ROUND;
            end
            ROUND: begin
                next  = 1'b1;
                round = t;
                w     = wSched;
                if (t == 7'd79) stateNext = FINAL;
            end
            FINAL: begin
                stateNext = lastBlk ? DONE : LOAD;
            end
            DONE: begin
                digest_valid = 1'b1;
`ifdef SHA1_CTRL_DIGEST_HOLD_EN
                if (digest_ack) stateNext = LOAD;
`else
                stateNext = LOAD;
`endif
            end
            default: stateNext = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            t       <= '0;
            lastBlk <= 1'b0;
            h0      <= IV0;
            h1      <= IV1;
            h2      <= IV2;
            h3      <= IV3;
            h4      <= IV4;
            for (int unsigned i = 0; i < 16; i++) wBuf[i] <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        wBuf[count] <= in_word;
                        count       <= count + 4'd1;
                        if (count == 4'd0 && in_init) begin
                            h0 <= IV0;
                            h1 <= IV1;
                            h2 <= IV2;
                            h3 <= IV3;
                            h4 <= IV4;
                        end
                        if (count == 4'd15) lastBlk <= in_last;
                    end
                end
                FEED: t <= '0;
                ROUND: begin
                    if (t >= 7'd16) wBuf[idx0] <= wSched;
                    t <= (t == 7'd79) ? 7'd0 : t + 7'd1;
                end
                FINAL: begin
                    h0    <= h0 + a;
                    h1    <= h1 + b;
                    h2    <= h2 + c;
                    h3    <= h3 + d;
                    h4    <= h4 + e;
                    count <= '0;
                end
                default: ;
            endcase
        end
    end

    assign ia     = h0;
    assign ib     = h1;
    assign ic     = h2;
    assign id     = h3;
    assign ie     = h4;
    assign digest = {h0, h1, h2, h3, h4};
    assign busy   = !(state == LOAD && count == 4'd0);

endmodule

// File: tb/tb_sha1_round_ctrl.sv
// Directed bench for sha1_round_ctrl with a behavioural SHA-1 round datapath attached to feed/next/w/round.
module tb_sha1_round_ctrl;

    localparam logic [159:0] IV_D    = 160'h67452301efcdab8998badcfe10325476c3d2e1f0;
    localparam logic [159:0] ABC_D   = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
    localparam logic [159:0] EMPTY_D = 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709;
    localparam logic [159:0] TWO_D   = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;

    localparam logic [511:0] ABC_B   = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] EMPTY_B = {32'h80000000, {15{32'h0}}};
    localparam logic [511:0] TWO_B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_B2  = {{15{32'h0}}, 32'h000001c0};

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, in_init, in_last;
    logic [31:0]  in_word;
    logic         feed, next, digest_valid, busy;
    logic [31:0]  w;
    logic [6:0]   round;
    logic [31:0]  ia, ib, ic, id, ie;
    logic [31:0]  dA, dB, dC, dD, dE;
    logic [159:0] digest;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sha1_round_ctrl dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .in_init(in_init), .in_last(in_last),
`ifdef SHA1_CTRL_DIGEST_HOLD_EN
        .digest_ack(1'b1),
`endif
        .feed(feed), .next(next), .w(w), .round(round),
        .ia(ia), .ib(ib), .ic(ic), .id(id), .ie(ie),
        .a(dA), .b(dB), .c(dC), .d(dD), .e(dE),
        .digest(digest), .digest_valid(digest_valid), .busy(busy)
    );

    function automatic logic [31:0] sha1Temp(input logic [6:0] t, input logic [31:0] va, vb, vc, vd, ve, wt);
        logic [31:0] f, k;
        if (t < 7'd20) begin
            f = (vb & vc) | (~vb & vd); k = 32'h5a827999;
        end else if (t < 7'd40) begin
            f = vb ^ vc ^ vd;           k = 32'h6ed9eba1;
        end else if (t < 7'd60) begin
            f = (vb & vc) | (vb & vd) | (vc & vd); k = 32'h8f1bbcdc;
        end else begin
            f = vb ^ vc ^ vd;           k = 32'hca62c1d6;
        end
        return {va[26:0], va[31:27]} + f + ve + k + wt;
    endfunction

    // Reference round datapath driven by the controller's strobes
    always @(posedge clk) begin
        if (feed) begin
            dA <= ia; dB <= ib; dC <= ic; dD <= id; dE <= ie;
        end else if (next) begin
            dA <= sha1Temp(round, dA, dB, dC, dD, dE, w);
            dB <= dA;
            dC <= {dB[1:0], dB[31:2]};
            dD <= dC;
            dE <= dD;
        end
    end

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sendBlock(input logic [511:0] blk, input logic init, input logic last,
                             input bit gaps, input bit monitor, output logic [159:0] dig);
        int bad;
        int waitCnt;
        int gapLen;
        dig = '0;
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                gapLen = $urandom_range(0, 2);
                for (int g = 0; g < gapLen; g++) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                end
            end
            waitCnt = 0;
            @(negedge clk);
            while (!in_ready && waitCnt < 300) begin
                @(negedge clk);
                waitCnt++;
            end
            if (!in_ready) begin
                check("readyTimeout", 160'(in_ready), 160'd1);
                in_valid = 1'b0;
                return;
            end
            in_valid = 1'b1;
            in_word  = blk[511 - 32*i -: 32];
            in_init  = (i == 0)  ? init : 1'b0;
            in_last  = (i == 15) ? last : 1'b0;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        if (!monitor) return;
        bad = 0;
        for (int k = 1; k <= 83; k++) begin
            @(negedge clk);
            if (k <= 82 && in_ready) bad++;
            if (k < 83 && !busy) bad++;
            if (k < 83 && digest_valid) bad++;
            if (k == 1 && !(feed && !next && w == 32'd0 && round == 7'd0)) bad++;
            if (k >= 2 && k <= 81 && !(next && !feed && round == 7'(k - 2))) bad++;
            if (k == 82 && (feed || next || w != 32'd0 || round != 7'd0)) bad++;
            if (k == 83) begin
                check(last ? "dvAt83" : "noPulse", 160'(digest_valid), 160'(last));
                check("readyAt83", 160'(in_ready), 160'(!last));
                if (last) dig = digest;
            end
        end
        check("sequence", 160'(bad), 160'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        int bad;
        bad = 0;
        if (in_ready !== 1'b1) bad++;
        if (feed !== 1'b0 || next !== 1'b0 || digest_valid !== 1'b0 || busy !== 1'b0) bad++;
        if (w !== 32'd0 || round !== 7'd0) bad++;
        check({tag, "Ctl"}, 160'(bad), 160'd0);
        check({tag, "Iv"}, digest, IV_D);
    endtask

    initial begin
        #300000;
        $display("FAIL globalTimeout got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [159:0] dig, d1, d2, d3;
        int n;
        reset = 1'b1; in_valid = 1'b0; in_word = '0; in_init = 1'b0; in_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        reset = 1'b0;

        sendBlock(ABC_B, 1'b1, 1'b1, 1'b0, 1'b1, dig);
        check("abc", dig, ABC_D);

        sendBlock(EMPTY_B, 1'b1, 1'b1, 1'b0, 1'b1, dig);
        check("empty", dig, EMPTY_D);

        sendBlock(TWO_B1, 1'b1, 1'b0, 1'b0, 1'b1, dig);
        sendBlock(TWO_B2, 1'b0, 1'b1, 1'b0, 1'b1, dig);
        check("twoBlock", dig, TWO_D);

        sendBlock(ABC_B, 1'b1, 1'b1, 1'b1, 1'b1, dig);
        check("abcGaps", dig, ABC_D);

        // Abort mid-block at round 40
        sendBlock(ABC_B, 1'b1, 1'b1, 1'b0, 1'b0, dig);
        n = 0;
        @(negedge clk);
        while (!(next && round == 7'd40) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reachRound40", 160'(round), 160'd40);
        reset = 1'b1;
        #1;
        checkResetOutputs("midReset");
        @(negedge clk);
        reset = 1'b0;
        sendBlock(ABC_B, 1'b1, 1'b1, 1'b0, 1'b1, dig);
        check("abcAfterReset", dig, ABC_D);

        sendBlock(ABC_B, 1'b1, 1'b1, 1'b0, 1'b1, d1);
        sendBlock(ABC_B, 1'b1, 1'b1, 1'b0, 1'b1, d2);
        check("b2bFirst", d1, ABC_D);
        check("b2bSecond", d2, ABC_D);
        sendBlock(ABC_B, 1'b0, 1'b1, 1'b0, 1'b1, d3);
        check("chainDiffers", 160'(d3 != ABC_D), 160'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
